lcd_capture_packer: RTL and testbench

Write-side counterpart of the LCD display path. Samples an RGB888 parallel video stream (DE/VSYNC framed), packs every 4 consecutive active pixels into one 96-bit SDRAM word using the same bit layout the display driver unpacks, and buffers the words in a small show-ahead FIFO toward the SDRAM write port. It also issues a per-frame SDRAM write-address reset pulse. It sits between the camera/video input pins and the SDRAM controller's write channel.

---
 rtl/lcd_capture_packer.sv | 150 +++++++++++++++
 tb/tb_lcd_capture_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture_packer.sv
// lcd_capture_packer
// Captures an RGB888 DE/VSYNC video stream, packs four pixels per 96-bit word
// (pixel 0 in the top 24 bits, each pixel as {B,G,R}), and queues the words in
// a show-ahead FIFO toward the SDRAM write channel. A synchronised VSYNC
// trailing edge produces a one-cycle write-address reset pulse and starts a
// new overflow-tracking window.
module lcd_capture_packer #(
  parameter int   FIFO_DEPTH = 4,
  parameter int   FIFO_AW    = 2,
  parameter logic VSYNC_ACT  = 1'b1
) (
  input  logic        clk_cap,
  input  logic        cap_rst_n,
  input  logic        cap_de,
  input  logic        cap_vsync,
  input  logic [7:0]  cap_r,
  input  logic [7:0]  cap_g,
  input  logic [7:0]  cap_b,
  output logic        sdr_wr_req,
  output logic [95:0] sdr_wr_data,
  input  logic        sdr_wr_ack,
  output logic        sdr_addr_set,
  output logic        cap_overflow,
  output logic        cap_framesync
);

  localparam int PW = FIFO_AW + 1;

  // VSYNC synchroniser and frame markers
  logic vs1_q, vs2_q;
  logic framesync_q;
  logic addr_set_q;
  logic frame_start;

  // Packing state
  logic        de_q;
  logic [1:0]  pix_cnt_q, pix_cnt_d;
  logic [71:0] part_q, part_d;
  logic [23:0] pixel;
  logic        push_req;
  logic [95:0] push_word;

  // FIFO state
  logic [95:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [95:0]   hold_q;
  logic          ovf_q, ovf_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_ok, drop;

  assign pixel       = {cap_b, cap_g, cap_r};
  assign frame_start = (vs2_q == VSYNC_ACT) && (vs1_q != VSYNC_ACT);

  // Pack incoming pixels; emit a word on the 4th pixel or on the DE falling edge
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default on any branch would infer a latch.
    pix_cnt_d = pix_cnt_q;
    part_d    = part_q;
    push_req  = 1'b0;
    push_word = '0;
    if (frame_start) begin
      pix_cnt_d = 2'd0;
      part_d    = '0;
    end else if (cap_de) begin
      pix_cnt_d = pix_cnt_q + 2'd1;
      case (pix_cnt_q)
        2'd0:    part_d[71:48] = pixel;
        2'd1:    part_d[47:24] = pixel;
        2'd2:    part_d[23:0]  = pixel;
        default: begin
          push_req  = 1'b1;
          push_word = {part_q, pixel};
          part_d    = '0;
        end
      endcase
    end else if (de_q && (pix_cnt_q != 2'd0)) begin
      // Unwritten slots are already zero because the partial register is
      // cleared after every emitted word.
      push_req  = 1'b1;
      push_word = {part_q, 24'h000000};
      pix_cnt_d = 2'd0;
      part_d    = '0;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop        = sdr_wr_ack && !fifo_empty;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // FIFO pointer advance and sticky per-frame overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = frame_start ? 1'b0 : (ovf_q | drop);
  end

  // Control and datapath registers
  always_ff @(posedge clk_cap or negedge cap_rst_n) begin
    if (!cap_rst_n) begin
      vs1_q       <= ~VSYNC_ACT;
      vs2_q       <= ~VSYNC_ACT;
      framesync_q <= 1'b0;
      addr_set_q  <= 1'b0;
      de_q        <= 1'b0;
      pix_cnt_q   <= 2'd0;
      part_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hold_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, so vs1_q -> vs2_q forms a true two-stage chain.
      vs1_q       <= cap_vsync;
      vs2_q       <= vs1_q;
      framesync_q <= (cap_vsync != VSYNC_ACT);
      addr_set_q  <= frame_start;
      de_q        <= cap_de;
      pix_cnt_q   <= pix_cnt_d;
      part_q      <= part_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      if (pop) begin
        hold_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_cap) begin
    // NOTE: the storage array has no reset; pointers define which entries are
    // valid, and leaving the array unreset lets it map onto plain RAM.
    if (push_ok) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= push_word;
    end
  end

  assign sdr_wr_req    = !fifo_empty;
  assign sdr_wr_data   = fifo_empty ? hold_q : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign sdr_addr_set  = addr_set_q;
  assign cap_overflow  = ovf_q;
  assign cap_framesync = framesync_q;

endmodule

// File: tb/tb_lcd_capture_packer.sv
// Testbench for lcd_capture_packer: directed scenarios followed by randomized
// lines and frames, checked against a pixel-queue reference model with a
// scoreboard of expected SDRAM words.
module tb_lcd_capture_packer;

  localparam int   DEPTH = 4;
  localparam int   AW    = 2;
  localparam logic ACT   = 1'b1;
  localparam logic INACT = ~ACT;

  logic        clk_cap;
  logic        cap_rst_n;
  logic        cap_de;
  logic        cap_vsync;
  logic [7:0]  cap_r, cap_g, cap_b;
  logic        sdr_wr_req;
  logic [95:0] sdr_wr_data;
  logic        sdr_wr_ack;
  logic        sdr_addr_set;
  logic        cap_overflow;
  logic        cap_framesync;

  lcd_capture_packer #(
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW   (AW),
    .VSYNC_ACT (ACT)
  ) dut (
    .clk_cap      (clk_cap),
    .cap_rst_n    (cap_rst_n),
    .cap_de       (cap_de),
    .cap_vsync    (cap_vsync),
    .cap_r        (cap_r),
    .cap_g        (cap_g),
    .cap_b        (cap_b),
    .sdr_wr_req   (sdr_wr_req),
    .sdr_wr_data  (sdr_wr_data),
    .sdr_wr_ack   (sdr_wr_ack),
    .sdr_addr_set (sdr_addr_set),
    .cap_overflow (cap_overflow),
    .cap_framesync(cap_framesync)
  );

  initial clk_cap = 1'b0;
  always #5 clk_cap = ~clk_cap;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [23:0] pix_q[$];
  logic [95:0] exp_q[$];
  int          model_cnt = 0;
  logic        vs_h1 = INACT;
  logic        vs_h2 = INACT;
  logic        exp_ovf = 1'b0;
  logic        exp_addr_set = 1'b0;
  logic        exp_fs = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Pixel i of a word sits at bits [95-24i -: 24]; missing pixels read as zero.
  function automatic logic [95:0] pack_pixels();
    logic [95:0] w;
    w = '0;
    foreach (pix_q[i]) w = w | ({72'h0, pix_q[i]} << (72 - 24 * i));
    return w;
  endfunction

  // One clock edge of the reference model, using the inputs applied at that edge.
  task automatic model_edge();
    logic        fs, pop_now, have;
    logic [95:0] word;
    fs      = (vs_h2 == ACT) && (vs_h1 != ACT);
    pop_now = sdr_wr_ack && (model_cnt > 0);
    have    = 1'b0;
    word    = '0;
    if (fs) begin
      pix_q.delete();
    end else if (cap_de) begin
      pix_q.push_back({cap_b, cap_g, cap_r});
      if (pix_q.size() == 4) begin
        word = pack_pixels();
        have = 1'b1;
        pix_q.delete();
      end
    end else if (pix_q.size() > 0) begin
      word = pack_pixels();
      have = 1'b1;
      pix_q.delete();
    end
    exp_addr_set = fs;
    if (fs) exp_ovf = 1'b0;
    if (have) begin
      if (model_cnt < DEPTH || pop_now) begin
        exp_q.push_back(word);
        model_cnt++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (pop_now) model_cnt--;
    vs_h2  = vs_h1;
    vs_h1  = cap_vsync;
    exp_fs = (cap_vsync != ACT);
  endtask

  // Apply inputs, clock one edge, advance the model and check status outputs.
  task automatic step(input logic de, input logic [23:0] bgr, input logic ack, input logic vs);
    cap_de     = de;
    cap_b      = bgr[23:16];
    cap_g      = bgr[15:8];
    cap_r      = bgr[7:0];
    sdr_wr_ack = ack;
    cap_vsync  = vs;
    @(posedge clk_cap);
    model_edge();
    #1;
    check("wr_req", {95'h0, sdr_wr_req}, {95'h0, (model_cnt > 0)});
    check("addr_set", {95'h0, sdr_addr_set}, {95'h0, exp_addr_set});
    check("overflow", {95'h0, cap_overflow}, {95'h0, exp_ovf});
    check("framesync", {95'h0, cap_framesync}, {95'h0, exp_fs});
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, ack, INACT);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {95'h0, sdr_wr_req}, 96'h0);
    check({tag, "_data"}, sdr_wr_data, 96'h0);
    check({tag, "_addr_set"}, {95'h0, sdr_addr_set}, 96'h0);
    check({tag, "_ovf"}, {95'h0, cap_overflow}, 96'h0);
    check({tag, "_fs"}, {95'h0, cap_framesync}, 96'h0);
  endtask

  // Asynchronous reset asserted between edges, released just after an edge.
  task automatic reset_midstream();
    cap_rst_n  = 1'b0;
    cap_de     = 1'b0;
    sdr_wr_ack = 1'b0;
    cap_vsync  = INACT;
    pix_q.delete();
    exp_q.delete();
    model_cnt    = 0;
    vs_h1        = INACT;
    vs_h2        = INACT;
    exp_ovf      = 1'b0;
    exp_addr_set = 1'b0;
    exp_fs       = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk_cap);
    @(posedge clk_cap);
    #1;
    check_reset_outputs("rst_hold");
    cap_rst_n = 1'b1;
  endtask

  // Scoreboard monitor: the head word must match whenever a word is offered.
  always @(negedge clk_cap) begin
    if (cap_rst_n && sdr_wr_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_data_unexpected: got %h expected no word", sdr_wr_data);
      end else begin
        check("wr_data", sdr_wr_data, exp_q[0]);
        if (sdr_wr_ack) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, pulse_at, len, gap;
    cap_rst_n  = 1'b0;
    cap_de     = 1'b0;
    cap_vsync  = INACT;
    cap_r      = 8'h0;
    cap_g      = 8'h0;
    cap_b      = 8'h0;
    sdr_wr_ack = 1'b0;
    #2;
    check_reset_outputs("por");
    @(posedge clk_cap);
    #1;
    cap_rst_n = 1'b1;
    idle(3, 1'b0);

    // Four known pixels form one word, offered right after the 4th edge
    step(1'b1, 24'h010203, 1'b0, INACT);
    step(1'b1, 24'h040506, 1'b0, INACT);
    step(1'b1, 24'h070809, 1'b0, INACT);
    step(1'b1, 24'h0A0B0C, 1'b0, INACT);
    check("t1_word", sdr_wr_data, 96'h010203_040506_070809_0A0B0C);
    idle(2, 1'b1);

    // Six-pixel line: second word is flushed with two zero slots
    for (int i = 0; i < 6; i++) step(1'b1, 24'h200000 + 24'(i), 1'b0, INACT);
    step(1'b0, 24'h0, 1'b0, INACT);
    step(1'b0, 24'h0, 1'b1, INACT);
    check("t2_flush_word", sdr_wr_data, 96'h200004_200005_000000_000000);
    idle(3, 1'b1);

    // Twenty pixels with no ack: four words held, fifth dropped
    for (int i = 0; i < 20; i++) step(1'b1, 24'h300000 + 24'(i), 1'b0, INACT);
    check("t3_overflow", {95'h0, cap_overflow}, 96'h1);
    idle(6, 1'b1);

    // VSYNC pulse: single addr_set pulse on the 2nd edge after release
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0, ACT);
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 24'h0, 1'b0, INACT);
      if (sdr_addr_set) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    check("t5_pulse_count", 96'(pulses), 96'd1);
    check("t5_pulse_pos", 96'(pulse_at), 96'd1);
    check("t5_ovf_cleared", {95'h0, cap_overflow}, 96'h0);

    // Full FIFO with push and ack on the same edge
    for (int i = 0; i < 20; i++) step(1'b1, 24'h400000 + 24'(i), (i == 19), INACT);
    check("t4_no_overflow", {95'h0, cap_overflow}, 96'h0);
    idle(6, 1'b1);

    // Reset mid-packing with two words queued, then a clean word
    for (int i = 0; i < 10; i++) step(1'b1, 24'h500000 + 24'(i), 1'b0, INACT);
    reset_midstream();
    step(1'b1, 24'hA1A2A3, 1'b0, INACT);
    step(1'b1, 24'hB1B2B3, 1'b0, INACT);
    step(1'b1, 24'hC1C2C3, 1'b0, INACT);
    step(1'b1, 24'hD1D2D3, 1'b0, INACT);
    check("t6_clean_word", sdr_wr_data, 96'hA1A2A3_B1B2B3_C1C2C3_D1D2D3);
    idle(3, 1'b1);

    // Randomized lines and frames with random back-pressure
    for (int line = 0; line < 80; line++) begin
      if (line % 10 == 9) begin
        idle(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'($urandom_range(0, 1)), ACT);
        idle(3, 1'($urandom_range(0, 1)));
      end
      len = $urandom_range(1, 14);
      gap = $urandom_range(1, 4);
      for (int i = 0; i < len; i++)
        step(1'b1, 24'($urandom), ($urandom_range(0, 2) == 0), INACT);
      for (int i = 0; i < gap; i++)
        step(1'b0, 24'($urandom), ($urandom_range(0, 1) == 0), INACT);
    end

    idle(DEPTH + 2, 1'b1);
    check("final_drained", 96'(exp_q.size()), 96'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
